// File: rtl/pri_decoder_dispatch.sv
// pri_decoder_dispatch: decodes an accepted code into a held one-hot grant released by ack or timeout
module pri_decoder_dispatch #(
  parameter int N       = 8,
  parameter int W       = 3,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_code,
  output logic         in_ready,
  output logic [N-1:0] out_onehot,
  output logic         out_valid,
  input  logic         out_ack,
  output logic         err_code,
  output logic         err_timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [W:0] NL = (W+1)'(N);
  localparam logic [7:0] TL = 8'(TIMEOUT - 1);
  state_t         state_q;
  logic [N-1:0]   onehot_q;
  logic           valid_q;
  logic           err_code_q;
  logic           err_to_q;
  logic [7:0]     cnt_q;
  // Grant FSM: capture code in IDLE, hold grant until ack or wait budget runs out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      onehot_q   <= '0;
      valid_q    <= 1'b0;
      err_code_q <= 1'b0;
      err_to_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      err_code_q <= 1'b0;
      err_to_q   <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          if ({1'b0, in_code} < NL) begin
            state_q  <= GRANT;
            onehot_q <= N'(1) << in_code;
            valid_q  <= 1'b1;
            cnt_q    <= '0;
          end else begin
            err_code_q <= 1'b1;
          end
        end
        GRANT: if (out_ack || cnt_q == TL) begin
          state_q  <= IDLE;
          onehot_q <= '0;
          valid_q  <= 1'b0;
          cnt_q    <= '0;
          err_to_q <= !out_ack;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      endcase
    end
  end
  assign in_ready    = (state_q == IDLE);
  assign out_onehot  = onehot_q;
  assign out_valid   = valid_q;
  assign err_code    = err_code_q;
  assign err_timeout = err_to_q;
endmodule

// File: doc/pri_decoder_dispatch.md
PRI_DECODER_DISPATCH -- requirements
Module: pri_decoder_dispatch

Interface
REQ-001 Parameter N, default 8: width of one-hot grant vector.
REQ-002 Parameter W, default 3: width of input code; SHALL satisfy 2**W >= N.
REQ-003 Parameter TIMEOUT, default 15: max cycles a grant waits for ack, range 1..255.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  code request present.
REQ-007 in_code  input  W  encoded index to decode.
REQ-008 in_ready  output  1  block can accept a code this cycle.
REQ-009 out_onehot  output  N  registered one-hot grant, bit in_code set.
REQ-010 out_valid  output  1  grant asserted.
REQ-011 out_ack  input  1  consumer acknowledges current grant.
REQ-012 err_code  output  1  one-cycle pulse: accepted code >= N.
REQ-013 err_timeout  output  1  one-cycle pulse: grant dropped without ack.

Function
REQ-014 FSM SHALL have exactly two states: IDLE, GRANT.
REQ-015 in_ready SHALL equal 1 in IDLE, 0 in GRANT (decoded from state register only, no combinational path from in_valid or out_ack).
REQ-016 Transfer occurs on a clock edge where in_valid=1 and in_ready=1.
REQ-017 Transfer with in_code < N: next cycle state=GRANT, out_onehot = 1 << in_code, out_valid=1; latency exactly 1 cycle.
REQ-018 Transfer with in_code >= N: state stays IDLE, out_onehot stays 0, err_code=1 for exactly the following cycle.
REQ-019 In GRANT, out_onehot SHALL hold its value unchanged, exactly one bit set, until leaving GRANT.
REQ-020 In IDLE, out_onehot SHALL be all zeros and out_valid=0.
REQ-021 8-bit wait counter SHALL clear to 0 on entry to GRANT and increment each GRANT cycle without ack.
REQ-022 GRANT with out_ack=1: next cycle IDLE, out_onehot=0, out_valid=0, no error pulse.
REQ-023 GRANT, out_ack=0, counter == TIMEOUT-1: next cycle IDLE, outputs cleared, err_timeout=1 for exactly that cycle.
REQ-024 Ack and timeout on same edge: ack wins, err_timeout stays 0.
REQ-025 out_ack in IDLE SHALL be ignored.
REQ-026 in_valid while in GRANT SHALL be ignored (not captured); source must hold it until in_ready.
REQ-027 Back-to-back requests: minimum 2 cycles per grant (one IDLE cycle between grants).
REQ-028 err_code and err_timeout SHALL never be high in the same cycle and SHALL be registered.
REQ-029 in_code SHALL be sampled only on the transfer edge; later changes have no effect on the held grant.

Reset
REQ-030 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, out_onehot=0, out_valid=0, err_code=0, err_timeout=0, counter=0.
REQ-031 Reset during GRANT SHALL drop the grant at once with no err_timeout pulse.
REQ-032 After rst_n deasserts, in_ready=1 from the first rising edge; first transfer possible on that edge.

Verification
REQ-033 Reset then in_valid=1, in_code=5 for one cycle -> next cycle out_onehot=8'b0010_0000, out_valid=1, in_ready=0.
REQ-034 Grant code 7 held, out_ack=1 at 4th GRANT cycle -> next cycle out_onehot=0, out_valid=0, err_timeout=0, in_ready=1.
REQ-035 Grant code 0, no ack, TIMEOUT=15 -> out_valid high exactly 15 cycles, then err_timeout=1 one cycle, out_onehot=0.
REQ-036 TIMEOUT=15, out_ack=1 on 15th GRANT cycle -> IDLE, err_timeout=0 (ack wins).
REQ-037 N=6, W=3, in_code=6 transfer -> err_code=1 one cycle, out_valid stays 0, in_ready stays 1.
REQ-038 rst_n pulled low mid-GRANT code 3 -> out_onehot=0 same cycle without clock edge, no error pulses after release.
